byte_serializer: RTL and testbench
==================================

// Module: byte_serializer
// PURPOSE
//   Consumes the 8-bit parallel word produced by the register/assign stage and shifts it
//   out one bit per clock with a valid/ready handshake on both sides.
//   Sits directly downstream of the parallel word register; feeds serial links and the
//   bit-level checkers. Supports back-to-back words with no idle bubble.
// PARAMETERS
//   WIDTH      8   word width in bits (>= 2)
//   MSB_FIRST  1   1: shift out bit WIDTH-1 first; 0: shift out bit 0 first
// PORTS
//   clk        in   1      single clock; all state updates on rising edge
//   rst_n      in   1      reset, synchronous, active-low
//   in_data    in   WIDTH  parallel word from upstream
//   in_valid   in   1      in_data valid
//   in_ready   out  1      serializer can accept a word this cycle
//   ser_out    out  1      current serial bit
//   ser_valid  out  1      ser_out valid
//   ser_ready  in   1      downstream accepts ser_out this cycle
//   ser_last   out  1      ser_out is the final bit of the word
//   busy       out  1      a word is in flight (state == SHIFT)
//   word_done  out  1      one-cycle pulse, cycle after the last bit is accepted
// BEHAVIOUR
//   - Reset (rst_n=0 at a clock edge):
//     state=IDLE, shreg=0, cnt=0, ser_valid=0, ser_out=0, ser_last=0, word_done=0.
//     in_ready=1 from the first cycle after reset.
//   - Reset mid-word: the in-flight word is discarded, no word_done, and no partial bits
//     are emitted after reset.
//   - States: IDLE, SHIFT. cnt is $clog2(WIDTH) bits and counts bits accepted downstream.
//   - IDLE: in_ready=1, ser_valid=0. On in_valid&&in_ready: shreg<=in_data, cnt<=0,
//     state<=SHIFT. First bit is valid on the next cycle (1-cycle load latency).
//   - SHIFT: ser_valid=1. ser_out=shreg[WIDTH-1] if MSB_FIRST, else shreg[0]
//     (combinational from shreg). ser_last=(cnt==WIDTH-1).
//   - Bit transfer occurs when ser_valid&&ser_ready: shreg shifts toward the output end,
//     zero-filled, and cnt increments.
//   - ser_ready=0: shreg, cnt and ser_out hold, and ser_valid stays 1.
//     Bit values never change while stalled.
//   - in_ready = (state==IDLE) || (ser_last && ser_ready). This is a combinational path
//     from ser_ready.
//   - Last-bit transfer with in_valid=1: the new word loads in the same edge, cnt<=0, and
//     the state stays SHIFT. The next word's first bit appears on the following cycle,
//     so there is no bubble.
//   - Last-bit transfer with in_valid=0: state<=IDLE.
//   - word_done: registered; high exactly one cycle after each last-bit transfer,
//     including the back-to-back case.
//   - in_valid while in SHIFT and not on the last-bit transfer: ignored (in_ready=0).
//     Upstream holds the word.
//   - Exactly WIDTH transfers per accepted word; no bit is dropped or duplicated.
// TESTING
//   1 rst_n=0 for 2 clks, in_valid=0 -> ser_valid=0, ser_out=0, word_done=0, in_ready=1, busy=0.
//   2 in_data=8'b10101010 for one cycle, ser_ready=1 -> ser_out=1,0,1,0,1,0,1,0 on 8
//     consecutive cycles starting 1 clk after load; ser_last only on the 8th; word_done
//     on the 9th; then IDLE.
//   3 Same word, ser_ready=0 during bits 3-5 -> bit 3 held for 3 extra cycles, sequence
//     unchanged, 8 transfers total, word_done after the 8th.
//   4 Back-to-back: 8'hA5 then 8'h3C, in_valid high, ser_ready=1 ->
//     16 contiguous bits 10100101 00111100, ser_valid never drops, two word_done pulses.
//   5 rst_n=0 after 3 bits of 8'hC3 -> ser_valid=0 next cycle, no word_done.
//     Then 8'hFF -> eight 1s and one word_done.
//   6 MSB_FIRST=0, in_data=8'b00000001 -> ser_out=1 then seven 0s; ser_last on the 8th bit.

Source files
------------

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - parallel word to bit-serial shifter with valid/ready on both sides
module byte_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             word_done_q, word_done_d;
  logic             shifting;
  logic             xfer;
  logic             load;

  assign shifting  = (state_q == ST_SHIFT);
  assign ser_valid = shifting;
  assign ser_out   = shifting & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
  assign ser_last  = shifting && (cnt_q == LAST_CNT);
  // Accepting on the last-bit transfer lets back-to-back words run without a bubble.
  assign in_ready  = !shifting || (ser_last && ser_ready);
  assign busy      = shifting;
  assign word_done = word_done_q;

  assign xfer = ser_valid && ser_ready;
  assign load = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    word_done_d = xfer && ser_last;
    if (load) begin
      shreg_d = in_data;
      cnt_d   = '0;
      state_d = ST_SHIFT;
    end else if (xfer) begin
      shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
      cnt_d   = cnt_q + CNT_W'(1);
      if (ser_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
    end
  end

endmodule

// File: tb/tb_byte_serializer.sv
// tb/tb_byte_serializer.sv - self-checking bench for byte_serializer
module tb_byte_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ser_out, ser_valid, ser_last, busy, word_done;
  logic       ser_ready = 1'b0;

  logic [7:0] in_data1 = 8'h00;
  logic       in_valid1 = 1'b0;
  logic       in_ready1;
  logic       ser_out1, ser_valid1, ser_last1, busy1, word_done1;
  logic       ser_ready1 = 1'b0;

  always #5 clk = ~clk;

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ser_out(ser_out), .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last),
    .busy(busy), .word_done(word_done)
  );

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .ser_out(ser_out1), .ser_valid(ser_valid1), .ser_ready(ser_ready1), .ser_last(ser_last1),
    .busy(busy1), .word_done(word_done1)
  );

  typedef struct {
    logic [7:0]  data;
    logic [15:0] stall;
    logic [7:0]  exp_seq;
    int          exp_cycles;
  } vec_t;

  typedef struct {
    logic b;
    logic last;
  } exp_bit_t;

  int       checks = 0;
  int       errors = 0;
  int       wd_cnt = 0;
  exp_bit_t exp_q[$];
  vec_t     vecs[6];
  logic     hold_v = 1'b0;
  logic     hold_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] seq);
    for (int i = 7; i >= 0; i--) begin
      exp_bit_t e;
      e.b    = seq[i];
      e.last = (i == 0);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard: every accepted bit must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ser_valid && ser_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_bit", 32'(ser_out) | 32'h100, 32'h0);
        end else begin
          exp_bit_t e;
          e = exp_q.pop_front();
          chk("ser_out", 32'(ser_out), 32'(e.b));
          chk("ser_last", 32'(ser_last), 32'(e.last));
        end
      end
      if (hold_v && ser_valid) chk("stall_hold", 32'(ser_out), 32'(hold_b));
      hold_v = ser_valid && !ser_ready;
      hold_b = ser_out;
      if (word_done) wd_cnt++;
    end else begin
      hold_v = 1'b0;
    end
  end

  task automatic run_word(input int idx);
    int c;
    push_word(vecs[idx].exp_seq);
    in_data   = vecs[idx].data;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (c = 0; c < 40; c++) begin
      ser_ready = (c < 16) ? !vecs[idx].stall[c] : 1'b1;
      #1;
      if (ser_last && !ser_ready) chk("in_ready_stalled_last", 32'(in_ready), 32'h0);
      step();
      if (exp_q.size() == 0) break;
    end
    chk("word_cycles", 32'(c + 1), 32'(vecs[idx].exp_cycles));
    chk("word_done_high", 32'(word_done), 32'h1);
    chk("busy_after_word", 32'(busy), 32'h0);
    chk("in_ready_idle", 32'(in_ready), 32'h1);
    step();
    chk("word_done_low", 32'(word_done), 32'h0);
    exp_q.delete();
  endtask

  initial begin
    int  wd0;
    int  c;
    logic gap;

    vecs[0] = '{data: 8'hAA, stall: 16'h0000, exp_seq: 8'b10101010, exp_cycles: 8};
    vecs[1] = '{data: 8'hAA, stall: 16'h001C, exp_seq: 8'b10101010, exp_cycles: 11};
    vecs[2] = '{data: 8'h81, stall: 16'h0000, exp_seq: 8'b10000001, exp_cycles: 8};
    vecs[3] = '{data: 8'h5C, stall: 16'h0101, exp_seq: 8'b01011100, exp_cycles: 10};
    vecs[4] = '{data: 8'h00, stall: 16'h0000, exp_seq: 8'b00000000, exp_cycles: 8};
    vecs[5] = '{data: 8'hFF, stall: 16'h0000, exp_seq: 8'b11111111, exp_cycles: 8};

    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_ser_valid", 32'(ser_valid), 32'h0);
    chk("rst_ser_out", 32'(ser_out), 32'h0);
    chk("rst_ser_last", 32'(ser_last), 32'h0);
    chk("rst_word_done", 32'(word_done), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 5; i++) run_word(i);

    // Back-to-back words must stream 16 bits without ser_valid dropping.
    wd0 = wd_cnt;
    push_word(8'hA5);
    push_word(8'h3C);
    in_data   = 8'hA5;
    in_valid  = 1'b1;
    ser_ready = 1'b1;
    step();
    in_data = 8'h3C;
    gap = 1'b0;
    for (c = 0; c < 40; c++) begin
      step();
      if (c == 7) in_valid = 1'b0;
      if (exp_q.size() == 0) break;
      if (!ser_valid) gap = 1'b1;
    end
    chk("b2b_cycles", 32'(c + 1), 32'd16);
    chk("b2b_no_gap", 32'(gap), 32'h0);
    step();
    chk("b2b_word_done_pulses", 32'(wd_cnt - wd0), 32'd2);
    exp_q.delete();

    // Reset after three bits: the remainder of the word must vanish.
    exp_q.push_back('{b: 1'b1, last: 1'b0});
    exp_q.push_back('{b: 1'b1, last: 1'b0});
    exp_q.push_back('{b: 1'b0, last: 1'b0});
    in_data  = 8'hC3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("midword_bits_seen", 32'(exp_q.size()), 32'h0);
    rst_n = 1'b0;
    step();
    wd0 = wd_cnt;
    rst_n = 1'b1;
    #1;
    chk("midrst_ser_valid", 32'(ser_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    step();
    step();
    step();
    chk("midrst_no_word_done", 32'(wd_cnt - wd0), 32'h0);
    wd0 = wd_cnt;
    run_word(5);
    chk("ff_word_done_count", 32'(wd_cnt - wd0), 32'h1);

    // LSB-first instance.
    in_data1   = 8'b00000001;
    in_valid1  = 1'b1;
    ser_ready1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("lsb_ser_valid", 32'(ser_valid1), 32'h1);
      chk("lsb_ser_out", 32'(ser_out1), (k == 0) ? 32'h1 : 32'h0);
      chk("lsb_ser_last", 32'(ser_last1), (k == 7) ? 32'h1 : 32'h0);
      step();
    end
    chk("lsb_word_done", 32'(word_done1), 32'h1);
    chk("lsb_idle", 32'(busy1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
